interrupt_ack_controller: RTL and testbench
===========================================

Name: interrupt_ack_controller

Overview:
- Consumer side of the PIC-8259 interrupt request register (IRR).
- Resolves priority among pending unmasked requests against the in-service register (ISR) and raises INT to the CPU.
- Runs the two-pulse 8086-style INTA handshake, driving the IRR `freeze` and `clear_interrupt_req` inputs.
- Returns the 8-bit vector on the data bus and retires ISR bits on EOI or automatic EOI (AEOI).

Parameters:
- SPURIOUS_IR, 3'd7, IR level reported and vectored when no valid request exists at the first INTA.
- FIXED_IR_COUNT, 8, number of IR lines; fixed by the protocol, any other value is illegal.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- interrupt_req_register  in  8  IRR contents.
- interrupt_mask  in  8  IMR; 1 = masked.
- inta_n  in  1  CPU acknowledge strobe, active-low, synchronous to clock.
- auto_eoi  in  1  1 = AEOI mode.
- eoi  in  1  one-cycle EOI command pulse.
- specific_eoi  in  1  qualifies `eoi`; 1 = clear `eoi_level` only.
- eoi_level  in  3  ISR bit targeted by a specific EOI.
- vector_base  in  5  ICW2 T7..T3.
- int_out  out  1  INT request to CPU.
- freeze  out  1  to IRR; holds edge-mode IRR bits during the acknowledge.
- clear_interrupt_req  out  8  to IRR; one-hot, one-cycle clear.
- in_service_register  out  8  ISR.
- data_out  out  8  vector byte.
- data_out_enable  out  1  data bus drive enable.

Behaviour:
- Reset: every output 0, state IDLE, inta_prev = 1. Reset asserted mid-handshake aborts to IDLE immediately; `freeze` drops the same edge.
- Priority: fixed, IR0 highest.
  - req_win = lowest-index bit of (IRR & ~IMR).
  - isr_top = lowest-index set ISR bit (none = 8).
  - pending = req_win exists and req_win < isr_top.
- INT: registered. In IDLE, int_out <= pending. Deasserts on the edge the first INTA fall is detected and stays low until the handshake returns to IDLE.
- Edge detection: inta_prev registers inta_n each cycle. fall = inta_prev & ~inta_n; rise = ~inta_prev & inta_n. All responses are registered on the same edge where fall or rise is evaluated, giving 1-cycle latency from the inta_n change.
- State machine:
  - IDLE --fall--> ACK1.
    - Latch winner = pending ? req_win : SPURIOUS_IR.
    - Latch spurious = ~pending.
    - freeze <= 1.
    - If not spurious: ISR[winner] <= 1, and clear_interrupt_req <= one-hot(winner) for exactly one cycle.
  - ACK1 --rise--> WAIT2. freeze remains 1.
  - WAIT2 --fall--> ACK2. data_out <= {vector_base, winner}; data_out_enable <= 1.
  - ACK2 --rise--> IDLE.
    - data_out_enable <= 0; data_out holds its value.
    - freeze <= 0.
    - If auto_eoi and not spurious: ISR[winner] <= 0.
- Falls seen in ACK1 or ACK2, and rises seen in IDLE or WAIT2, are impossible given edge detection; the state is held.
- `clear_interrupt_req` is 0 in every cycle except the single ACK1-entry cycle.
- EOI (accepted in any state):
  - Non-specific: clear isr_top; no-op if ISR = 0.
  - Specific: clear ISR[eoi_level].
  - EOI in the same cycle as the ISR set at ACK1 entry: clear is computed on the old ISR, then the set is applied. The new bit survives unless it is the EOI target.
- Masking or IRR changes after ACK1 entry do not alter the latched winner or vector.
- Nested operation: a higher-priority request while an ISR bit is set re-raises int_out in IDLE. Equal or lower priority does not.

Decomposition:
- Shared package `pic_pkg`:
  - state enum {IDLE, ACK1, WAIT2, ACK2}.
  - localparam IR_COUNT = 8.
  - function `lowest_set_index(8b) -> 4b`, returning 8 when none is set.
- Sub-module `priority_resolver`: combinational. Inputs IRR, IMR, ISR; outputs req_win, isr_top, pending. Reusable later for rotating priority.

Test Plan:
- Basic acknowledge:
  - Stimulus: reset; IRR = 0x08, IMR = 0, vector_base = 5'h08, auto_eoi = 0, two INTA pulses.
  - Response: int_out = 1; at first fall, clear = 0x08 for one cycle, ISR = 0x08, freeze = 1; second pulse gives data_out = 0x43 with enable; freeze = 0 after rise; ISR stays 0x08 until a non-specific EOI clears it.
- Priority and masking:
  - Stimulus: IRR = 0x06, IMR = 0x02.
  - Response: winner IR2, vector {base, 3'd2}, clear = 0x04.
- Nesting:
  - Stimulus: ISR = 0x10 with IRR = 0x20, then IRR = 0x01.
  - Response: int_out stays 0 for IR5; rises for IR0; after acknowledge, ISR = 0x11; non-specific EOI leaves 0x10.
- Spurious:
  - Stimulus: request removed before the first INTA fall.
  - Response: clear = 0, ISR unchanged, vector {base, 3'd7}.
- AEOI plus simultaneous EOI:
  - Stimulus: auto_eoi = 1; specific EOI on level 3 in the ACK1-entry cycle for winner IR1, with ISR = 0x08.
  - Response: after the second rise, ISR = 0x00.
- Reset in WAIT2:
  - Stimulus: assert reset while in WAIT2.
  - Response: next edge gives freeze = 0, int_out = 0, ISR = 0, state IDLE; a subsequent INTA pulse sequence acknowledges normally.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259-style interrupt acknowledge logic.
package pic_pkg;

  localparam int unsigned IR_COUNT = 8;
  localparam int unsigned IDX_W    = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACK1,
    WAIT2,
    ACK2
  } state_e;

  // Index of the lowest set bit, or IR_COUNT when the vector is empty.
  function automatic logic [IDX_W-1:0] lowest_set_index(input logic [IR_COUNT-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = IDX_W'(IR_COUNT);
    for (int i = IR_COUNT - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [IR_COUNT-1:0] ir_onehot(input logic [2:0] idx);
    return IR_COUNT'(1) << idx;
  endfunction

endpackage

// File: rtl/priority_resolver.sv
// Fixed-priority (IR0 highest) resolution of unmasked requests against the ISR.
module priority_resolver
  import pic_pkg::*;
(
  input  logic [IR_COUNT-1:0] irr,
  input  logic [IR_COUNT-1:0] imr,
  input  logic [IR_COUNT-1:0] isr,
  output logic [IDX_W-1:0]    req_win,
  output logic [IDX_W-1:0]    isr_top,
  output logic                pending
);

  always_comb begin
    req_win = lowest_set_index(irr & ~imr);
    isr_top = lowest_set_index(isr);
    // An empty request set yields IR_COUNT, which never beats isr_top.
    pending = (req_win < isr_top);
  end

endmodule

// File: rtl/interrupt_ack_controller.sv
// INT generation, two-pulse INTA handshake, vector return and ISR/EOI bookkeeping.
module interrupt_ack_controller
  import pic_pkg::*;
#(
  parameter logic [2:0]  SPURIOUS_IR    = 3'd7,
  parameter int unsigned FIXED_IR_COUNT = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [IR_COUNT-1:0] interrupt_req_register,
  input  logic [IR_COUNT-1:0] interrupt_mask,
  input  logic                inta_n,
  input  logic                auto_eoi,
  input  logic                eoi,
  input  logic                specific_eoi,
  input  logic [2:0]          eoi_level,
  input  logic [4:0]          vector_base,
  output logic                int_out,
  output logic                freeze,
  output logic [IR_COUNT-1:0] clear_interrupt_req,
  output logic [IR_COUNT-1:0] in_service_register,
  output logic [7:0]          data_out,
  output logic                data_out_enable
);

  if (FIXED_IR_COUNT != IR_COUNT) begin : g_bad_ir_count
    $error("interrupt_ack_controller: FIXED_IR_COUNT must be 8");
  end

  state_e              state_q, state_d;
  logic                inta_prev_q;
  logic [2:0]          winner_q, winner_d;
  logic                spurious_q, spurious_d;
  logic                int_out_q, int_out_d;
  logic                freeze_q, freeze_d;
  logic [IR_COUNT-1:0] clear_q, clear_d;
  logic [IR_COUNT-1:0] isr_q, isr_d;
  logic [7:0]          data_out_q, data_out_d;
  logic                data_oe_q, data_oe_d;

  logic [IDX_W-1:0]    req_win;
  logic [IDX_W-1:0]    isr_top;
  logic                pending;
  logic                inta_fall;
  logic                inta_rise;
  logic [IR_COUNT-1:0] isr_set;
  logic [IR_COUNT-1:0] isr_aeoi_clr;
  logic [IR_COUNT-1:0] eoi_clr;
  logic                unused_req_msb;

  priority_resolver u_resolver (
    .irr     (interrupt_req_register),
    .imr     (interrupt_mask),
    .isr     (isr_q),
    .req_win (req_win),
    .isr_top (isr_top),
    .pending (pending)
  );

  // Bit 3 only flags "none"; pending already covers that case.
  assign unused_req_msb = req_win[3];

  assign inta_fall = inta_prev_q & ~inta_n;
  assign inta_rise = ~inta_prev_q & inta_n;

  // EOI target is taken from the ISR as it stood before this edge.
  always_comb begin
    eoi_clr = '0;
    if (eoi) begin
      if (specific_eoi) begin
        eoi_clr = ir_onehot(eoi_level);
      end else if (!isr_top[3]) begin
        eoi_clr = ir_onehot(isr_top[2:0]);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    winner_d     = winner_q;
    spurious_d   = spurious_q;
    int_out_d    = 1'b0;
    freeze_d     = freeze_q;
    clear_d      = '0;
    data_out_d   = data_out_q;
    data_oe_d    = data_oe_q;
    isr_set      = '0;
    isr_aeoi_clr = '0;

    unique case (state_q)
      IDLE: begin
        int_out_d = pending & ~inta_fall;
        if (inta_fall) begin
          state_d    = ACK1;
          winner_d   = pending ? req_win[2:0] : SPURIOUS_IR;
          spurious_d = ~pending;
          freeze_d   = 1'b1;
          if (pending) begin
            isr_set = ir_onehot(req_win[2:0]);
            clear_d = ir_onehot(req_win[2:0]);
          end
        end
      end
      ACK1: begin
        if (inta_rise) state_d = WAIT2;
      end
      WAIT2: begin
        if (inta_fall) begin
          state_d    = ACK2;
          data_out_d = {vector_base, winner_q};
          data_oe_d  = 1'b1;
        end
      end
      ACK2: begin
        if (inta_rise) begin
          state_d   = IDLE;
          data_oe_d = 1'b0;
          freeze_d  = 1'b0;
          if (auto_eoi && !spurious_q) isr_aeoi_clr = ir_onehot(winner_q);
        end
      end
      default: state_d = IDLE;
    endcase

    // A same-cycle EOI aimed at the newly set bit wins over the set.
    isr_d = (isr_q | isr_set) & ~eoi_clr & ~isr_aeoi_clr;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      inta_prev_q <= 1'b1;
      winner_q    <= '0;
      spurious_q  <= 1'b0;
      int_out_q   <= 1'b0;
      freeze_q    <= 1'b0;
      clear_q     <= '0;
      isr_q       <= '0;
      data_out_q  <= '0;
      data_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      inta_prev_q <= inta_n;
      winner_q    <= winner_d;
      spurious_q  <= spurious_d;
      int_out_q   <= int_out_d;
      freeze_q    <= freeze_d;
      clear_q     <= clear_d;
      isr_q       <= isr_d;
      data_out_q  <= data_out_d;
      data_oe_q   <= data_oe_d;
    end
  end

  assign int_out             = int_out_q;
  assign freeze              = freeze_q;
  assign clear_interrupt_req = clear_q;
  assign in_service_register = isr_q;
  assign data_out            = data_out_q;
  assign data_out_enable     = data_oe_q;

endmodule

// File: tb/tb_interrupt_ack_controller.sv
// Directed scenarios plus random traffic, checked every cycle against a behavioural model.
module tb_interrupt_ack_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] irr = '0;
  logic [7:0] imr = '0;
  logic       inta_n = 1'b1;
  logic       auto_eoi = 1'b0;
  logic       eoi = 1'b0;
  logic       specific_eoi = 1'b0;
  logic [2:0] eoi_level = '0;
  logic [4:0] vector_base = 5'h08;

  logic       int_out;
  logic       freeze;
  logic [7:0] clear_interrupt_req;
  logic [7:0] in_service_register;
  logic [7:0] data_out;
  logic       data_out_enable;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: handshake progress counts INTA edges seen (0..3).
  bit         m_prev = 1'b1;
  int         m_edges = 0;
  int         m_win = 0;
  bit         m_spur = 1'b0;
  bit         m_int = 1'b0;
  bit         m_frz = 1'b0;
  logic [7:0] m_clr = '0;
  logic [7:0] m_isr = '0;
  logic [7:0] m_dat = '0;
  bit         m_oe = 1'b0;

  interrupt_ack_controller dut (
    .clock                  (clock),
    .reset                  (reset),
    .interrupt_req_register (irr),
    .interrupt_mask         (imr),
    .inta_n                 (inta_n),
    .auto_eoi               (auto_eoi),
    .eoi                    (eoi),
    .specific_eoi           (specific_eoi),
    .eoi_level              (eoi_level),
    .vector_base            (vector_base),
    .int_out                (int_out),
    .freeze                 (freeze),
    .clear_interrupt_req    (clear_interrupt_req),
    .in_service_register    (in_service_register),
    .data_out               (data_out),
    .data_out_enable        (data_out_enable)
  );

  always #5 clock = ~clock;

  function automatic int first_bit(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 8;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit fall, rise, pend;
    int req, top, target;
    logic [7:0] nisr;
    if (reset) begin
      m_prev = 1'b1; m_edges = 0; m_win = 0; m_spur = 1'b0; m_int = 1'b0;
      m_frz = 1'b0; m_clr = '0; m_isr = '0; m_dat = '0; m_oe = 1'b0;
      return;
    end
    fall = m_prev && !inta_n;
    rise = !m_prev && inta_n;
    req  = first_bit(irr & ~imr);
    top  = first_bit(m_isr);
    pend = (req < 8) && (req < top);
    nisr = m_isr;
    target = 8;
    if (eoi) target = specific_eoi ? int'(eoi_level) : top;
    if (target < 8) nisr[target] = 1'b0;
    m_clr = '0;
    m_int = (m_edges == 0 && !fall) ? pend : 1'b0;
    case (m_edges)
      0: if (fall) begin
        m_win  = pend ? req : 7;
        m_spur = !pend;
        m_frz  = 1'b1;
        if (pend) begin
          nisr[m_win] = (target == m_win) ? 1'b0 : 1'b1;
          m_clr[m_win] = 1'b1;
        end
        m_edges = 1;
      end
      1: if (rise) m_edges = 2;
      2: if (fall) begin
        m_dat = {vector_base, 3'(m_win)};
        m_oe  = 1'b1;
        m_edges = 3;
      end
      default: if (rise) begin
        m_oe  = 1'b0;
        m_frz = 1'b0;
        if (auto_eoi && !m_spur) nisr[m_win] = 1'b0;
        m_edges = 0;
      end
    endcase
    m_isr  = nisr;
    m_prev = inta_n;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
    chk("int_out", 8'(int_out), 8'(m_int));
    chk("freeze", 8'(freeze), 8'(m_frz));
    chk("clear", clear_interrupt_req, m_clr);
    chk("isr", in_service_register, m_isr);
    chk("data_out", data_out, m_dat);
    chk("data_oe", 8'(data_out_enable), 8'(m_oe));
  endtask

  // Full two-pulse acknowledge with fixed expectations; any pending EOI is dropped after the first fall.
  task automatic inta_seq(input string tag, input logic [7:0] exp_clr, input logic [7:0] exp_vec);
    inta_n = 1'b0; tick(); eoi = 1'b0;
    chk({tag, "_clr"}, clear_interrupt_req, exp_clr);
    chk({tag, "_frz1"}, 8'(freeze), 8'd1);
    chk({tag, "_int_low"}, 8'(int_out), 8'd0);
    tick();
    chk({tag, "_clr_once"}, clear_interrupt_req, 8'h00);
    inta_n = 1'b1; tick();
    chk({tag, "_frz_wait2"}, 8'(freeze), 8'd1);
    inta_n = 1'b0; tick();
    chk({tag, "_vec"}, data_out, exp_vec);
    chk({tag, "_oe"}, 8'(data_out_enable), 8'd1);
    inta_n = 1'b1; tick();
    chk({tag, "_oe_off"}, 8'(data_out_enable), 8'd0);
    chk({tag, "_frz0"}, 8'(freeze), 8'd0);
    chk({tag, "_vec_hold"}, data_out, exp_vec);
  endtask

  initial begin
    #1;
    tick(); tick();
    chk("rst_isr", in_service_register, 8'h00);
    chk("rst_int", 8'(int_out), 8'd0);
    reset = 1'b0;

    // Basic acknowledge of IR3
    irr = 8'h08; tick();
    chk("basic_int", 8'(int_out), 8'd1);
    inta_seq("basic", 8'h08, 8'h43);
    chk("basic_isr", in_service_register, 8'h08);
    irr = 8'h00; tick(); tick();
    chk("basic_isr_kept", in_service_register, 8'h08);
    eoi = 1'b1; specific_eoi = 1'b0; tick(); eoi = 1'b0;
    chk("basic_eoi", in_service_register, 8'h00);

    // Priority with IR1 masked
    irr = 8'h06; imr = 8'h02; tick();
    chk("prio_int", 8'(int_out), 8'd1);
    inta_seq("prio", 8'h04, 8'h42);
    irr = 8'h00; imr = 8'h00;
    eoi = 1'b1; tick(); eoi = 1'b0;
    chk("prio_eoi", in_service_register, 8'h00);

    // Nesting above IR4
    irr = 8'h10; tick();
    inta_seq("nest_ir4", 8'h10, 8'h44);
    irr = 8'h20; tick(); tick();
    chk("nest_low_no_int", 8'(int_out), 8'd0);
    irr = 8'h01; tick();
    chk("nest_high_int", 8'(int_out), 8'd1);
    inta_seq("nest_ir0", 8'h01, 8'h40);
    chk("nest_isr", in_service_register, 8'h11);
    irr = 8'h00; eoi = 1'b1; tick(); eoi = 1'b0;
    chk("nest_eoi", in_service_register, 8'h10);
    eoi = 1'b1; tick(); eoi = 1'b0;

    // Spurious: request vanishes before the first fall
    irr = 8'h04; tick();
    irr = 8'h00;
    inta_seq("spur", 8'h00, 8'h47);
    chk("spur_isr", in_service_register, 8'h00);

    // AEOI with a specific EOI on level 3 at ACK1 entry
    irr = 8'h08; tick();
    inta_seq("aeoi_pre", 8'h08, 8'h43);
    irr = 8'h02; auto_eoi = 1'b1; tick();
    eoi = 1'b1; specific_eoi = 1'b1; eoi_level = 3'd3;
    inta_seq("aeoi", 8'h02, 8'h41);
    chk("aeoi_isr", in_service_register, 8'h00);
    irr = 8'h00; auto_eoi = 1'b0; specific_eoi = 1'b0; tick();

    // Reset while waiting for the second pulse
    irr = 8'h01; tick();
    inta_n = 1'b0; tick();
    inta_n = 1'b1; tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst_wait2_frz", 8'(freeze), 8'd0);
    chk("rst_wait2_int", 8'(int_out), 8'd0);
    chk("rst_wait2_isr", in_service_register, 8'h00);
    tick();
    inta_seq("post_rst", 8'h01, 8'h40);
    irr = 8'h00; eoi = 1'b1; tick(); eoi = 1'b0;

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) irr = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) imr = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) inta_n = ~inta_n;
      eoi = ($urandom_range(0, 9) == 0);
      specific_eoi = 1'($urandom_range(0, 1));
      eoi_level = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) auto_eoi = ~auto_eoi;
      if ($urandom_range(0, 99) == 0) vector_base = 5'($urandom_range(0, 31));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
